l2_req_arbiter: RTL and testbench

Sequences and shares the single L2 cache port between the L1 instruction cache and L1 data cache, both of which move 128-bit lines. It accepts one miss/writeback at a time, latches it, and drives the L2 read/write handshake with a 32-byte-aligned address. It also drives the L2 bus adapter's half-select, write data and write mask, and returns the selected 128-bit half to the winning requester. It sits between the two L1 caches and the `l2_bus_adapter` / L2 cache.

---
 rtl/l2_arb_pkg.sv | 6 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/l2_req_arbiter.sv | 90 +++++++++
 tb/tb_l2_req_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg: shared types and constants for the L2 request arbiter
package l2_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
  typedef enum logic {ICACHE, DCACHE} arb_owner_t;
  localparam int L2_OFFSET_BITS = 5;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way picker, one-hot grant {dcache, icache}, round-robin or dcache priority
module rr_arbiter2
  import l2_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rr_en,
  input  logic       req_i,
  input  logic       req_d,
  input  logic       take,
  output logic [1:0] gnt
);
  arb_owner_t last_grant;
  always_comb gnt = (req_i && req_d) ? ((rr_en && last_grant == DCACHE) ? 2'b01 : 2'b10) : {req_d, req_i};
  always_ff @(posedge clk or posedge rst)
    if (rst) last_grant <= ICACHE;
    else if (take && (req_i || req_d)) last_grant <= gnt[1] ? DCACHE : ICACHE;
endmodule

// File: rtl/l2_req_arbiter.sv
// l2_req_arbiter: serialises icache/dcache line requests onto the single L2 port
module l2_req_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int MASK_W = LINE_W / 8,
  parameter int RR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_resp,
  output logic              shift_bit,
  output logic [LINE_W-1:0] arb_wdata,
  output logic [MASK_W-1:0] arb_wmask,
  input  logic [LINE_W-1:0] arb_rdata
);
  arb_state_t        state;
  arb_owner_t        owner;
  logic              op_w;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic [1:0]        gnt;

  rr_arbiter2 u_pick (
    .clk   (clk),
    .rst   (rst),
    .rr_en (RR_EN != 0),
    .req_i (i_read),
    .req_d (d_read || d_write),
    .take  (state == IDLE),
    .gnt   (gnt)
  );

  // d_write wins over d_read if both are (illegally) high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= ICACHE;
      op_w   <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      i_resp <= 1'b0;
      d_resp <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      if (state == IDLE && gnt != 2'b00) begin
        owner <= gnt[1] ? DCACHE : ICACHE;
        op_w  <= gnt[1] && d_write;
        addr  <= gnt[1] ? d_addr : i_addr;
        wdata <= gnt[1] ? d_wdata : '0;
        state <= BUSY;
      end else if (state == BUSY && l2_resp) begin
        rdata  <= arb_rdata;
        i_resp <= owner == ICACHE;
        d_resp <= owner == DCACHE;
        state  <= RESP;
      end else if (state == RESP) begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    l2_read   = state == BUSY && !op_w;
    l2_write  = state == BUSY && op_w;
    l2_addr   = {addr[ADDR_W-1:L2_OFFSET_BITS], {L2_OFFSET_BITS{1'b0}}};
    shift_bit = addr[L2_OFFSET_BITS-1];
    arb_wdata = wdata;
    arb_wmask = {MASK_W{l2_write}};
    i_rdata   = rdata;
    d_rdata   = rdata;
  end
endmodule

// File: tb/tb_l2_req_arbiter.sv
// tb_l2_req_arbiter: randomized and directed checks of both arbitration modes against a transaction model
module tb_l2_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic         i_read [2];
  logic [31:0]  i_addr [2];
  logic [127:0] i_rdata [2];
  logic         i_resp [2];
  logic         d_read [2];
  logic         d_write [2];
  logic [31:0]  d_addr [2];
  logic [127:0] d_wdata [2];
  logic [127:0] d_rdata [2];
  logic         d_resp [2];
  logic         l2_read [2];
  logic         l2_write [2];
  logic [31:0]  l2_addr [2];
  logic         l2_resp [2];
  logic         shift_bit [2];
  logic [127:0] arb_wdata [2];
  logic [15:0]  arb_wmask [2];
  logic [127:0] arb_rdata [2];
  int checks = 0;
  int errors = 0;
  int lastg [2];

  always #5 clk = ~clk;

  // unit 0: dcache fixed priority, unit 1: round-robin
  for (genvar g = 0; g < 2; g++) begin : g_dut
    l2_req_arbiter #(.RR_EN(g)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_read    (i_read[g]),
      .i_addr    (i_addr[g]),
      .i_rdata   (i_rdata[g]),
      .i_resp    (i_resp[g]),
      .d_read    (d_read[g]),
      .d_write   (d_write[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_rdata   (d_rdata[g]),
      .d_resp    (d_resp[g]),
      .l2_read   (l2_read[g]),
      .l2_write  (l2_write[g]),
      .l2_addr   (l2_addr[g]),
      .l2_resp   (l2_resp[g]),
      .shift_bit (shift_bit[g]),
      .arb_wdata (arb_wdata[g]),
      .arb_wmask (arb_wmask[g]),
      .arb_rdata (arb_rdata[g])
    );
  end

  always @(negedge clk)
    for (int u = 0; u < 2; u++)
      assert (!(d_read[u] && d_write[u])) else $error("illegal d_read and d_write both high on unit %0d", u);

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) chk("strobe_excl", l2_read[u] && l2_write[u], 0);
    end
  endtask

  task automatic chk_zero(input int u);
    chk("z_l2_read", l2_read[u], 0);
    chk("z_l2_write", l2_write[u], 0);
    chk("z_l2_addr", l2_addr[u], 0);
    chk("z_shift", shift_bit[u], 0);
    chk("z_wdata", arb_wdata[u], 0);
    chk("z_wmask", arb_wmask[u], 0);
    chk("z_i_resp", i_resp[u], 0);
    chk("z_d_resp", d_resp[u], 0);
    chk("z_i_rdata", i_rdata[u], 0);
    chk("z_d_rdata", d_rdata[u], 0);
  endtask

  task automatic clear_inputs();
    for (int u = 0; u < 2; u++) begin
      i_read[u] = 0; i_addr[u] = 0; d_read[u] = 0; d_write[u] = 0;
      d_addr[u] = 0; d_wdata[u] = 0; l2_resp[u] = 0; arb_rdata[u] = 0;
      lastg[u] = 0;
    end
  endtask

  // called at the negedge of the first BUSY cycle of a grant
  task automatic serve(input int u, input int dly);
    int w;
    logic [31:0] a;
    logic wr;
    logic [127:0] r;
    logic ip, dp;
    ip = i_read[u];
    dp = d_read[u] || d_write[u];
    w = (ip && dp) ? ((u == 1 && lastg[u] == 1) ? 0 : 1) : (dp ? 1 : 0);
    lastg[u] = w;
    a = w == 1 ? d_addr[u] : i_addr[u];
    wr = w == 1 && d_write[u];
    for (int k = 0; k < 2; k++) begin
      chk("l2_read", l2_read[u], !wr);
      chk("l2_write", l2_write[u], wr);
      chk("l2_addr", l2_addr[u], {a[31:5], 5'b0});
      chk("shift_bit", shift_bit[u], a[4]);
      chk("arb_wmask", arb_wmask[u], wr ? 16'hFFFF : 16'h0);
      if (wr) chk("arb_wdata", arb_wdata[u], d_wdata[u]);
      chk("busy_i_resp", i_resp[u], 0);
      chk("busy_d_resp", d_resp[u], 0);
      if (k == 0) step(dly);
    end
    r = rnd128();
    arb_rdata[u] = r;
    l2_resp[u] = 1;
    step(1);
    l2_resp[u] = 0;
    arb_rdata[u] = rnd128();
    chk("i_resp", i_resp[u], w == 0);
    chk("d_resp", d_resp[u], w == 1);
    if (w == 1) chk("d_rdata", d_rdata[u], r);
    else chk("i_rdata", i_rdata[u], r);
    chk("resp_l2_read", l2_read[u], 0);
    chk("resp_l2_write", l2_write[u], 0);
    if (w == 1) begin d_read[u] = 0; d_write[u] = 0; end
    else i_read[u] = 0;
    step(1);
    chk("idle_i_resp", i_resp[u], 0);
    chk("idle_d_resp", d_resp[u], 0);
    chk("idle_l2_read", l2_read[u], 0);
    chk("idle_l2_write", l2_write[u], 0);
    chk("rdata_hold", w == 1 ? d_rdata[u] : i_rdata[u], r);
  endtask

  task automatic run(input int u, input bit ir, input bit dr, input bit dw,
                     input logic [31:0] ia, input logic [31:0] da, input logic [127:0] wd,
                     input int d1, input int d2);
    i_read[u] = ir; i_addr[u] = ia;
    d_read[u] = dr && !dw; d_write[u] = dr && dw;
    d_addr[u] = da; d_wdata[u] = wd;
    step(1);
    serve(u, d1);
    if (i_read[u] || d_read[u] || d_write[u]) begin
      step(1);
      serve(u, d2);
    end
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    step(1);
    rst = 0;
  endtask

  initial begin
    clear_inputs();
    step(2);
    for (int u = 0; u < 2; u++) chk_zero(u);
    rst = 0;
    step(1);
    // lone icache read, then dcache writeback
    run(1, 1, 0, 0, 32'h0000_1230, 32'h0, 128'h0, 3, 0);
    run(1, 0, 1, 1, 32'h0, 32'h8000_0040, rnd128(), 1, 0);
    run(0, 1, 0, 0, 32'h0000_1230, 32'h0, 128'h0, 0, 0);
    // ties after reset: dcache first both times in both modes
    do_reset();
    run(1, 1, 1, 0, $urandom, $urandom, rnd128(), 0, 0);
    run(1, 1, 1, 1, $urandom, $urandom, rnd128(), 2, 1);
    run(0, 1, 1, 0, $urandom, $urandom, rnd128(), 0, 1);
    run(0, 1, 1, 1, $urandom, $urandom, rnd128(), 1, 0);
    // last grant dcache then a tie: round-robin favours icache, fixed keeps dcache
    run(1, 0, 1, 0, $urandom, $urandom, rnd128(), 0, 0);
    run(1, 1, 1, 0, $urandom, $urandom, rnd128(), 0, 0);
    run(0, 0, 1, 0, $urandom, $urandom, rnd128(), 0, 0);
    run(0, 1, 1, 0, $urandom, $urandom, rnd128(), 0, 0);
    // reset two cycles into BUSY during a tie
    do_reset();
    i_read[1] = 1; i_addr[1] = $urandom;
    d_read[1] = 1; d_addr[1] = $urandom;
    step(1);
    chk("pre_rst_l2_read", l2_read[1], 1);
    step(1);
    #2 rst = 1;
    #1 chk_zero(1);
    step(1);
    chk_zero(1);
    rst = 0;
    lastg[0] = 0; lastg[1] = 0;
    step(1);
    serve(1, 0);
    step(1);
    serve(1, 1);
    // spurious l2_resp in IDLE
    l2_resp[1] = 1; arb_rdata[1] = rnd128();
    step(1);
    l2_resp[1] = 0;
    chk("spur_i_resp", i_resp[1], 0);
    chk("spur_d_resp", d_resp[1], 0);
    chk("spur_l2_read", l2_read[1], 0);
    step(1);
    chk("spur_i_resp2", i_resp[1], 0);
    chk("spur_l2_write", l2_write[1], 0);
    run(1, 1, 0, 0, $urandom, $urandom, rnd128(), 0, 0);
    // randomized traffic on both modes
    for (int k = 0; k < 40; k++) begin
      int u;
      bit ir, dr;
      u = k % 2;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1;
      run(u, ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, rnd128(),
          $urandom_range(0, 3), $urandom_range(0, 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
